// File: rtl/beatmap_sequencer.sv
// rtl/beatmap_sequencer.sv - beatmap ROM stepper emitting note-spawn events on a free-running beat grid
// One ROM entry is fetched per beat; non-zero lane masks become valid/ready spawn events.
module beatmap_sequencer #(
  parameter int BEAT_DIV = 12500000,
  parameter int MAP_LEN  = 17,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              note_valid,
  output logic [3:0]        note_lanes,
  input  logic              note_ready,
  output logic [ADDR_W-1:0] beat_idx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(MAP_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_lanes;
  logic              r_valid;
  logic [ADDR_W-1:0] r_bidx;
  logic              r_busy;
  logic              r_done;
  logic              r_ovr;

  logic [2:0] w_next_state;
  logic       w_active;
  logic       w_start;
  logic       w_tick;
  logic       w_beat_end;
  logic       w_capture;
  logic       w_load;

  assign w_active   = (r_state == S_FETCH) || (r_state == S_CAPTURE) || (r_state == S_RUN);
  assign w_start    = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_tick     = w_active && !pause;
  assign w_beat_end = (r_state == S_RUN) && !pause && (r_cnt == CNT_LAST);
  assign w_capture  = (r_state == S_CAPTURE) && !abort;
  assign w_load     = w_capture && (rom_data != 4'd0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_FETCH;
      S_FETCH:        w_next_state = S_CAPTURE;
      S_CAPTURE:      w_next_state = (r_idx == IDX_LAST) ? S_DONE : S_RUN;
      S_RUN:          if (w_beat_end) w_next_state = S_FETCH;
      default:        w_next_state = S_IDLE;
    endcase
    if (abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_lanes <= 4'd0;
      r_valid <= 1'b0;
      r_bidx  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_FETCH) || (w_next_state == S_CAPTURE) ||
                 (w_next_state == S_RUN);
      r_done  <= (w_next_state == S_DONE);

      if (abort || w_start || w_beat_end) r_cnt <= '0;
      else if (w_tick)                    r_cnt <= r_cnt + 1'b1;

      // The index saturates at the last entry; replay needs a fresh start.
      if (w_start) begin
        r_idx <= '0;
        r_ovr <= 1'b0;
      end else if (w_capture) begin
        r_bidx <= r_idx;
        if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
      end

      if (abort) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_lanes <= rom_data;
        r_valid <= 1'b1;
        if (r_valid && !note_ready) r_ovr <= 1'b1;
      end else if (r_valid && note_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rom_addr   = r_idx;
  assign note_valid = r_valid;
  assign note_lanes = r_lanes;
  assign beat_idx   = r_bidx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_beatmap_sequencer.sv
// tb/tb_beatmap_sequencer.sv - scoreboard bench for beatmap_sequencer
// A beat-level reference model feeds expected status/acceptances to a negedge monitor.
module tb_beatmap_sequencer;

  localparam int BD  = 4;
  localparam int LEN = 17;
  localparam int AW  = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn = 1'b1;
  logic          start = 1'b0, pause = 1'b0, abort = 1'b0, note_ready = 1'b0;
  logic [AW-1:0] rom_addr, beat_idx;
  logic [3:0]    rom_data = 4'd0, note_lanes;
  logic          note_valid, busy, done, overrun;

  logic          s1_start = 1'b0, s1_pause = 1'b0, s1_abort = 1'b0, s1_ready = 1'b0;
  logic [AW-1:0] s1_addr, s1_bidx;
  logic [3:0]    s1_data = 4'd0, s1_lanes;
  logic          s1_valid, s1_busy, s1_done, s1_ovr;

  logic [3:0] map [LEN];

  beatmap_sequencer #(.BEAT_DIV(BD), .MAP_LEN(LEN), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_valid(note_valid),
    .note_lanes(note_lanes), .note_ready(note_ready), .beat_idx(beat_idx),
    .busy(busy), .done(done), .overrun(overrun)
  );

  beatmap_sequencer #(.BEAT_DIV(BD), .MAP_LEN(1), .ADDR_W(AW)) dut_one (
    .clk(clk), .resetn(resetn), .start(s1_start), .pause(s1_pause), .abort(s1_abort),
    .rom_addr(s1_addr), .rom_data(s1_data), .note_valid(s1_valid),
    .note_lanes(s1_lanes), .note_ready(s1_ready), .beat_idx(s1_bidx),
    .busy(s1_busy), .done(s1_done), .overrun(s1_ovr)
  );

  always @(posedge clk) begin
    rom_data <= (rom_addr < AW'(LEN)) ? map[rom_addr[4:0]] : 4'd0;
    s1_data  <= (s1_addr == '0) ? 4'b1001 : 4'd0;
  end

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n++;

  typedef struct packed {
    logic          v;
    logic [3:0]    l;
    logic [AW-1:0] bi;
    logic          b;
    logic          d;
    logic          o;
    logic [AW-1:0] a;
  } stat_t;

  typedef struct {
    logic [3:0] l;
    int         c;
  } acc_t;

  stat_t stat_q[$];
  acc_t  acc_q[$];

  // Reference: a beat lasts BD unpaused cycles counted from its fetch; the event appears two edges after the fetch.
  bit         m_active, m_done, m_valid, m_ovr;
  logic [3:0] m_lanes;
  int         m_entry, m_bidx, m_since, m_ticks;

  task automatic push_status();
    stat_t s;
    s.v  = m_valid;
    s.l  = m_lanes;
    s.bi = AW'(m_bidx);
    s.b  = m_active;
    s.d  = m_done;
    s.o  = m_ovr;
    s.a  = AW'(m_entry);
    stat_q.push_back(s);
  endtask

  task automatic model_step();
    logic [3:0] d;
    bit         load;
    acc_t       ac;
    if (!resetn) begin
      m_active = 0; m_done = 0; m_valid = 0; m_ovr = 0; m_lanes = 4'd0;
      m_entry = 0; m_bidx = 0; m_since = 0; m_ticks = 0;
      push_status();
      return;
    end
    push_status();
    if (m_valid && note_ready) begin
      ac.l = m_lanes;
      ac.c = cyc_n;
      acc_q.push_back(ac);
    end
    if (abort) begin
      m_active = 0; m_done = 0; m_valid = 0; m_ticks = 0;
      return;
    end
    load = 0;
    d    = 4'd0;
    if (m_active) begin
      if (m_since == 1) begin
        d      = map[m_entry];
        load   = (d != 4'd0);
        m_bidx = m_entry;
        if (m_entry == LEN - 1) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_entry++;
        end
      end
      if (!pause) m_ticks++;
      m_since++;
      if (m_active && m_ticks == BD) begin
        m_ticks = 0;
        m_since = 0;
      end
    end else if (start) begin
      m_active = 1; m_done = 0; m_entry = 0; m_since = 0; m_ticks = 0; m_ovr = 0;
    end
    if (load) begin
      if (m_valid && !note_ready) m_ovr = 1;
      m_lanes = d;
      m_valid = 1;
    end else if (m_valid && note_ready) begin
      m_valid = 0;
    end
  endtask

  always @(negedge clk) begin
    stat_t e, a;
    acc_t  x;
    if (stat_q.size() > 0) begin
      e = stat_q.pop_front();
      a = {note_valid, note_lanes, beat_idx, busy, done, overrun, rom_addr};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL status cyc=%0d got v=%b l=%b bidx=%0d busy=%b done=%b ovr=%b addr=%0d want v=%b l=%b bidx=%0d busy=%b done=%b ovr=%b addr=%0d",
                 cyc_n, a.v, a.l, a.bi, a.b, a.d, a.o, a.a, e.v, e.l, e.bi, e.b, e.d, e.o, e.a);
      end
    end
    if (note_valid === 1'b1 && note_ready) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL accept cyc=%0d got lanes=%b want no acceptance", cyc_n, note_lanes);
      end else begin
        x = acc_q.pop_front();
        if (x.l !== note_lanes || x.c != cyc_n) begin
          errors++;
          $display("FAIL accept got lanes=%b cyc=%0d want lanes=%b cyc=%0d", note_lanes, cyc_n, x.l, x.c);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load_base_map();
    map[0] = 4'b1111; map[1] = 4'b1010; map[2] = 4'b0110; map[3] = 4'b0101;
    for (int i = 4; i < LEN; i++) map[i] = 4'($urandom_range(1, 15));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    load_base_map();
    #1 resetn = 1'b0;
    @(posedge clk);
    #2;
    cyc(3);
    resetn = 1'b1;
    cyc(2);

    // Nominal run, always ready.
    note_ready = 1'b1;
    pulse_start();
    cyc(2);
    check("first_valid", 32'(note_valid), 32'd1);
    check("first_lanes", 32'(note_lanes), 32'hF);
    cyc(4);
    check("second_lanes", 32'(note_lanes), 32'hA);
    cyc(64);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_bidx", 32'(beat_idx), 32'd16);

    // Rest at entry 2, plus a start while busy.
    map[2] = 4'b0000;
    pulse_start();
    cyc(10);
    check("rest_no_valid", 32'(note_valid), 32'd0);
    check("rest_bidx", 32'(beat_idx), 32'd2);
    cyc(4);
    check("after_rest_lanes", 32'(note_lanes), 32'(map[3]));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(59);

    // Back-pressure across two beats.
    load_base_map();
    note_ready = 1'b0;
    pulse_start();
    cyc(6);
    check("ovr_lanes", 32'(note_lanes), 32'hA);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(note_valid), 32'd1);
    note_ready = 1'b1;
    cyc(1);
    check("ovr_accepted", 32'(note_valid), 32'd0);
    cyc(66);
    check("ovr_sticky", 32'(overrun), 32'd1);
    pulse_start();
    check("ovr_cleared", 32'(overrun), 32'd0);
    cyc(70);

    // Pause mid-run, then pause during a fetch.
    pulse_start();
    cyc(5);
    pause = 1'b1;
    cyc(10);
    pause = 1'b0;
    cyc(4);
    check("pause_not_yet", 32'(note_valid), 32'd0);
    cyc(1);
    check("pause_delayed", 32'(note_valid), 32'd1);
    check("pause_lanes", 32'(note_lanes), 32'(map[2]));
    cyc(2);
    pause = 1'b1;
    cyc(2);
    check("pause_fetch_valid", 32'(note_valid), 32'd1);
    check("pause_fetch_lanes", 32'(note_lanes), 32'(map[3]));
    pause = 1'b0;
    cyc(80);

    // Abort during capture of entry 5.
    note_ready = 1'b0;
    pulse_start();
    cyc(21);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_valid", 32'(note_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bidx", 32'(beat_idx), 32'd4);
    pulse_start();
    check("restart_ovr", 32'(overrun), 32'd0);
    check("restart_addr", 32'(rom_addr), 32'd0);
    cyc(2);
    check("restart_lanes", 32'(note_lanes), 32'hF);
    note_ready = 1'b1;
    cyc(70);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      for (int i = 0; i < LEN; i++) map[i] = 4'($urandom_range(0, 15));
      pulse_start();
      for (int c = 0; c < 90; c++) begin
        note_ready = ($urandom % 4) != 0;
        pause      = ($urandom % 8) == 0;
        abort      = ($urandom % 200) == 0;
        start      = ($urandom % 50) == 0;
        cyc(1);
      end
      start = 1'b0; abort = 1'b0; pause = 1'b0;
    end

    // Asynchronous reset mid-run with an event pending.
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    load_base_map();
    note_ready = 1'b0;
    pulse_start();
    cyc(3);
    check("pre_reset_valid", 32'(note_valid), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("areset_valid", 32'(note_valid), 32'd0);
    check("areset_lanes", 32'(note_lanes), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_addr", 32'(rom_addr), 32'd0);
    check("areset_bidx", 32'(beat_idx), 32'd0);
    check("areset_ovr", 32'(overrun), 32'd0);
    cyc(2);
    resetn = 1'b1;
    cyc(2);

    // Single-entry map.
    s1_start = 1'b1;
    cyc(1);
    s1_start = 1'b0;
    cyc(3);
    check("one_done", 32'(s1_done), 32'd1);
    check("one_busy", 32'(s1_busy), 32'd0);
    check("one_bidx", 32'(s1_bidx), 32'd0);
    check("one_valid", 32'(s1_valid), 32'd1);
    check("one_lanes", 32'(s1_lanes), 32'h9);

    check("acc_drained", 32'(acc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
